// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the execute-stage branch controller:
//   - conditional-branch funct3 encodings
//   - controller FSM state encoding
//   - helper that sizes the post-redirect flush down-counter
// Also provides a default for the REG_WIDTH macro when the build does not
// define one, so PC/immediate/target width follows the core configuration.
// -----------------------------------------------------------------------------
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

package branch_pkg;

    // Conditional-branch funct3 encodings (010 and 011 are unused/illegal).
    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMPARE  = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_FLUSH    = 2'd3
    } branch_state_e;

    // Width of the flush down-counter; one extra bit so FLUSH_DEPTH-1 always
    // fits, including the power-of-two depths.
    function automatic int flush_cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/branch_taken_dec.sv
// -----------------------------------------------------------------------------
// branch_taken_dec
// Purely combinational branch outcome decode. Kept separate so a future
// predictor-update path can reuse exactly the same taken/illegal rules.
//
// Ports:
//   funct3_i  [2:0] in  : branch funct3
//   eq_i            in  : comparator equal result
//   lt_i            in  : comparator less-than result
//   taken_o         out : branch condition is true (legal funct3 only)
//   illegal_o       out : funct3 is 010 or 011
//   un_o            out : comparator must use the unsigned compare
// -----------------------------------------------------------------------------
module branch_taken_dec
    import branch_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       eq_i,
    input  logic       lt_i,
    output logic       taken_o,
    output logic       illegal_o,
    output logic       un_o
);

    always_comb begin
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        case (funct3_i)
            BEQ:        taken_o   = eq_i;
            BNE:        taken_o   = !eq_i;
            BLT, BLTU:  taken_o   = lt_i;
            BGE, BGEU:  taken_o   = !lt_i;
            default:    illegal_o = 1'b1;
        endcase
    end

    // BLTU/BGEU are the only encodings with bit 1 set among legal branches.
    assign un_o = funct3_i[1];

endmodule

// File: rtl/branch_ctrl.sv
// -----------------------------------------------------------------------------
// branch_ctrl
// Execute-stage sequencing controller for the external branch comparator.
// Accepts one conditional branch at a time from decode, enables the
// comparator for one (possibly stalled) COMPARE cycle, resolves the outcome,
// and on a taken branch issues a one-cycle PC redirect followed by a flush of
// FLUSH_DEPTH cycles in total. Static prediction is not-taken, so only taken
// branches redirect. Keeps saturating counts of resolved and taken branches.
//
// Parameters:
//   REG_WIDTH   : width of PC, immediate and redirect target
//   FLUSH_DEPTH : cycles flush is held per taken branch (1..8)
//   CNT_WIDTH   : width of the statistics counters
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   br_valid / br_ready   : decode handshake for a branch
//   br_funct3/br_pc/br_imm: branch payload (imm already sign-extended)
//   stall                 : pipeline stall; holds IDLE/COMPARE only
//   cmp_en, br_un         : comparator enable and unsigned-select
//   br_eq, br_lt          : comparator results, sampled at end of COMPARE
//   redirect, redirect_pc : one-cycle taken pulse and branch target
//   flush                 : kill younger instructions
//   illegal               : one-cycle pulse for funct3 010/011
//   branch_cnt, taken_cnt : saturating statistics
// -----------------------------------------------------------------------------
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int REG_WIDTH   = `REG_WIDTH,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 br_valid,
    output logic                 br_ready,
    input  logic [2:0]           br_funct3,
    input  logic [REG_WIDTH-1:0] br_pc,
    input  logic [REG_WIDTH-1:0] br_imm,
    input  logic                 stall,
    output logic                 cmp_en,
    output logic                 br_un,
    input  logic                 br_eq,
    input  logic                 br_lt,
    output logic                 redirect,
    output logic [REG_WIDTH-1:0] redirect_pc,
    output logic                 flush,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] branch_cnt,
    output logic [CNT_WIDTH-1:0] taken_cnt
);

    localparam int FCW = flush_cnt_width(FLUSH_DEPTH);

    // Control state
    branch_state_e        state_q, state_d;
    logic [FCW-1:0]       fcnt_q, fcnt_d;
    logic                 illegal_q, illegal_d;
    logic [REG_WIDTH-1:0] rpc_q, rpc_d;
    logic [CNT_WIDTH-1:0] bcnt_q, bcnt_d;
    logic [CNT_WIDTH-1:0] tcnt_q, tcnt_d;

    // Captured branch payload (data only, no reset needed)
    logic [2:0]           funct3_q;
    logic [REG_WIDTH-1:0] pc_q;
    logic [REG_WIDTH-1:0] imm_q;

    logic accept;
    logic dec_taken;
    logic dec_illegal;
    logic dec_un;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    branch_taken_dec u_dec (
        .funct3_i  (funct3_q),
        .eq_i      (br_eq),
        .lt_i      (br_lt),
        .taken_o   (dec_taken),
        .illegal_o (dec_illegal),
        .un_o      (dec_un)
    );

    // Next-state and Moore outputs
    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        illegal_d = 1'b0;
        rpc_d     = rpc_q;
        bcnt_d    = bcnt_q;
        tcnt_d    = tcnt_q;
        accept    = 1'b0;
        br_ready  = 1'b0;
        cmp_en    = 1'b0;
        br_un     = 1'b0;
        redirect  = 1'b0;
        flush     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Not ready while reset is asserted, so no branch is
                // half-accepted across a reset edge.
                br_ready = !stall && !rst;
                if (br_valid && br_ready) begin
                    accept  = 1'b1;
                    state_d = ST_COMPARE;
                end
            end

            ST_COMPARE: begin
                cmp_en = 1'b1;
                br_un  = dec_un;
                if (!stall) begin
                    if (dec_illegal) begin
                        illegal_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        bcnt_d = sat_inc(bcnt_q);
                        if (dec_taken) begin
                            tcnt_d  = sat_inc(tcnt_q);
                            // Target wraps modulo 2^REG_WIDTH by construction.
                            rpc_d   = pc_q + imm_q;
                            state_d = ST_REDIRECT;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end

            ST_REDIRECT: begin
                redirect = 1'b1;
                flush    = 1'b1;
                if (FLUSH_DEPTH > 1) begin
                    fcnt_d  = FCW'(FLUSH_DEPTH - 1);
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_FLUSH: begin
                // The redirect cycle is the first flush cycle; this state
                // covers the remaining FLUSH_DEPTH-1 and ignores stall.
                flush = 1'b1;
                if (fcnt_q <= FCW'(1)) begin
                    fcnt_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    fcnt_d = fcnt_q - FCW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            fcnt_q    <= '0;
            illegal_q <= 1'b0;
            rpc_q     <= '0;
            bcnt_q    <= '0;
            tcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            illegal_q <= illegal_d;
            rpc_q     <= rpc_d;
            bcnt_q    <= bcnt_d;
            tcnt_q    <= tcnt_d;
        end
    end

    // Branch payload capture
    always_ff @(posedge clk) begin
        if (accept) begin
            funct3_q <= br_funct3;
            pc_q     <= br_pc;
            imm_q    <= br_imm;
        end
    end

    assign illegal     = illegal_q;
    assign redirect_pc = rpc_q;
    assign branch_cnt  = bcnt_q;
    assign taken_cnt   = tcnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
`timescale 1ns/1ps
module tb_branch_ctrl;
    import branch_pkg::*;

    localparam int RW   = 32;
    localparam int FD   = 2;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          br_valid;
    logic          br_ready;
    logic [2:0]    br_funct3;
    logic [RW-1:0] br_pc;
    logic [RW-1:0] br_imm;
    logic          stall;
    logic          cmp_en;
    logic          br_un;
    logic          br_eq;
    logic          br_lt;
    logic          redirect;
    logic [RW-1:0] redirect_pc;
    logic          flush;
    logic          illegal;
    logic [CW-1:0] branch_cnt;
    logic [CW-1:0] taken_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_ctrl #(
        .REG_WIDTH   (RW),
        .FLUSH_DEPTH (FD),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .br_valid    (br_valid),
        .br_ready    (br_ready),
        .br_funct3   (br_funct3),
        .br_pc       (br_pc),
        .br_imm      (br_imm),
        .stall       (stall),
        .cmp_en      (cmp_en),
        .br_un       (br_un),
        .br_eq       (br_eq),
        .br_lt       (br_lt),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .flush       (flush),
        .illegal     (illegal),
        .branch_cnt  (branch_cnt),
        .taken_cnt   (taken_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the branch at transaction level: waiting for resolution, then a
    // number of flush cycles remaining; outputs follow from those quantities.
    bit            m_ok = 1'b0;
    bit            m_cmp;
    int            m_flush;
    bit            m_redir;
    bit            m_ill;
    logic [2:0]    m_f3;
    logic [RW-1:0] m_pc;
    logic [RW-1:0] m_imm;
    logic [RW-1:0] m_rpc;
    int            m_bcnt;
    int            m_tcnt;

    function automatic bit ref_taken(input logic [2:0] f3, input logic eq, input logic lt);
        case (f3)
            3'b000:         return eq;
            3'b001:         return !eq;
            3'b100, 3'b110: return lt;
            default:        return !lt;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ok = 1'b1; m_cmp = 1'b0; m_flush = 0; m_redir = 1'b0; m_ill = 1'b0;
            m_rpc = '0; m_bcnt = 0; m_tcnt = 0;
        end else if (m_ok) begin
            m_redir = 1'b0;
            m_ill   = 1'b0;
            if (m_cmp) begin
                if (!stall) begin
                    m_cmp = 1'b0;
                    if (m_f3 == 3'b010 || m_f3 == 3'b011) begin
                        m_ill = 1'b1;
                    end else begin
                        if (m_bcnt < CMAX) m_bcnt++;
                        if (ref_taken(m_f3, br_eq, br_lt)) begin
                            if (m_tcnt < CMAX) m_tcnt++;
                            m_redir = 1'b1;
                            m_flush = FD;
                            m_rpc   = m_pc + m_imm;
                        end
                    end
                end
            end else if (m_flush > 0) begin
                m_flush--;
            end else if (br_valid && !stall) begin
                m_cmp = 1'b1;
                m_f3  = br_funct3;
                m_pc  = br_pc;
                m_imm = br_imm;
            end
        end
    end

    // Per-cycle comparison against the model, 1 ns after the active edge.
    always @(posedge clk) begin
        #1;
        if (m_ok) begin
            chk("m.cmp_en",      cmp_en,      m_cmp);
            chk("m.br_un",       br_un,       m_cmp && m_f3[1]);
            chk("m.redirect",    redirect,    m_redir);
            chk("m.flush",       flush,       m_flush > 0);
            chk("m.illegal",     illegal,     m_ill);
            chk("m.redirect_pc", redirect_pc, m_rpc);
            chk("m.branch_cnt",  branch_cnt,  m_bcnt);
            chk("m.taken_cnt",   taken_cnt,   m_tcnt);
            chk("m.br_ready",    br_ready,    !rst && !m_cmp && m_flush == 0 && !stall);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the
    // COMPARE cycle (T+1).
    task automatic issue(input logic [2:0] f3, input logic [RW-1:0] pc,
                         input logic [RW-1:0] imm, input logic eq, input logic lt);
        stall     = 1'b0;
        br_valid  = 1'b1;
        br_funct3 = f3;
        br_pc     = pc;
        br_imm    = imm;
        br_eq     = eq;
        br_lt     = lt;
        #1;
        chk("ready_before_accept", br_ready, 1'b1);
        @(posedge clk);
        step();
        br_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; br_valid = 1'b0; br_funct3 = '0; br_pc = '0; br_imm = '0;
        stall = 1'b0; br_eq = 1'b0; br_lt = 1'b0;
        step(); step();

        // Reset state
        chk("rst.flush",       flush,       1'b0);
        chk("rst.redirect_pc", redirect_pc, 32'h0);
        chk("rst.branch_cnt",  branch_cnt,  2'd0);
        chk("rst.taken_cnt",   taken_cnt,   2'd0);
        chk("rst.ready_in_rst", br_ready,   1'b0);
        rst = 1'b0;
        #1;
        chk("rst.ready_after", br_ready, 1'b1);

        // BEQ taken
        issue(BEQ, 32'h100, 32'h20, 1'b1, 1'b0);
        chk("beq.cmp_en_T1", cmp_en, 1'b1);
        chk("beq.br_un_T1",  br_un,  1'b0);
        step();
        chk("beq.redirect_T2",    redirect,    1'b1);
        chk("beq.redirect_pc_T2", redirect_pc, 32'h120);
        chk("beq.flush_T2",       flush,       1'b1);
        chk("beq.taken_cnt_T2",   taken_cnt,   2'd1);
        chk("beq.ready_T2",       br_ready,    1'b0);
        step();
        chk("beq.redirect_T3", redirect, 1'b0);
        chk("beq.flush_T3",    flush,    1'b1);
        chk("beq.ready_T3",    br_ready, 1'b0);
        step();
        chk("beq.flush_T4", flush,    1'b0);
        chk("beq.ready_T4", br_ready, 1'b1);

        // BGEU not taken
        reset_dut();
        issue(BGEU, 32'h300, 32'h40, 1'b0, 1'b1);
        chk("bgeu.br_un_T1",  br_un,  1'b1);
        chk("bgeu.cmp_en_T1", cmp_en, 1'b1);
        step();
        chk("bgeu.redirect_T2",   redirect,   1'b0);
        chk("bgeu.branch_cnt_T2", branch_cnt, 2'd1);
        chk("bgeu.taken_cnt_T2",  taken_cnt,  2'd0);
        chk("bgeu.ready_T2",      br_ready,   1'b1);

        // Illegal funct3
        reset_dut();
        issue(3'b010, 32'h400, 32'h8, 1'b1, 1'b1);
        step();
        chk("ill.illegal_T2",    illegal,    1'b1);
        chk("ill.flush_T2",      flush,      1'b0);
        chk("ill.branch_cnt_T2", branch_cnt, 2'd0);
        chk("ill.taken_cnt_T2",  taken_cnt,  2'd0);
        chk("ill.ready_T2",      br_ready,   1'b1);
        step();
        chk("ill.illegal_T3", illegal, 1'b0);

        // Stall in COMPARE for 3 cycles, target wrap-around
        reset_dut();
        issue(BLT, 32'hFFFF_FFF0, 32'h20, 1'b0, 1'b1);
        stall = 1'b1;
        #1;
        chk("stall.cmp_en_T1", cmp_en, 1'b1);
        step();
        chk("stall.cmp_en_T2",   cmp_en,   1'b1);
        chk("stall.redirect_T2", redirect, 1'b0);
        step();
        chk("stall.cmp_en_T3", cmp_en, 1'b1);
        step();
        chk("stall.cmp_en_T4",   cmp_en,   1'b1);
        chk("stall.redirect_T4", redirect, 1'b0);
        stall = 1'b0;
        step();
        chk("stall.redirect_T5",    redirect,    1'b1);
        chk("stall.redirect_pc_T5", redirect_pc, 32'h0000_0010);
        stall = 1'b1;
        step();
        chk("stall.flush_T6",    flush,    1'b1);
        chk("stall.redirect_T6", redirect, 1'b0);
        step();
        chk("stall.flush_T7",  flush,    1'b0);
        chk("stall.ready_stalled_T7", br_ready, 1'b0);
        stall = 1'b0;
        #1;
        chk("stall.ready_T7", br_ready, 1'b1);

        // Reset during FLUSH
        reset_dut();
        issue(BNE, 32'h200, 32'h40, 1'b0, 1'b0);
        step();
        chk("rstfl.redirect_pc_T2", redirect_pc, 32'h240);
        step();
        chk("rstfl.flush_T3", flush, 1'b1);
        rst = 1'b1;
        step();
        chk("rstfl.flush",       flush,       1'b0);
        chk("rstfl.redirect",    redirect,    1'b0);
        chk("rstfl.taken_cnt",   taken_cnt,   2'd0);
        chk("rstfl.branch_cnt",  branch_cnt,  2'd0);
        chk("rstfl.redirect_pc", redirect_pc, 32'h0);
        rst = 1'b0;
        #1;
        chk("rstfl.ready", br_ready, 1'b1);

        // Every funct3 with every comparator result, checked by the model
        step();
        for (int f = 0; f < 8; f++) begin
            for (int c = 0; c < 4; c++) begin
                issue(3'(f), RW'(f * 32'h100 + c * 4), RW'(c * 8), c[0], c[1]);
                repeat (4) step();
            end
        end

        // Counter saturation: 5 taken branches with 2-bit counters
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            issue(BEQ, RW'(i * 16), 32'h4, 1'b1, 1'b0);
            repeat (3) step();
            if (i == 0) chk("sat.taken_cnt_first", taken_cnt, 2'd1);
        end
        chk("sat.taken_cnt",  taken_cnt,  2'd3);
        chk("sat.branch_cnt", branch_cnt, 2'd3);

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
